// File: rtl/fft_4x4_out_serializer.sv
// fft_4x4_out_serializer
//   Buffers one 4x4 complex FFT result frame (16 real + 16 imaginary words)
//   on an fft_done pulse, then streams it out one element per beat over a
//   valid/ready handshake, in row-major or column-major order.
//
// Parameters
//   ORDER  : 0 = row-major (element k on beat k), 1 = column-major
//   MAG_EN : 1 = m_mag carries |re|+|im|, 0 = m_mag tied to zero
//
// Ports
//   clk                         : single clock, rising edge
//   reset                       : asynchronous, active-low
//   fft_done                    : one-cycle frame-ready pulse, din_* valid while high
//   din_real_0..15 / din_imag_0..15 : frame words, element n = row n/4, col n%4
//   m_valid / m_ready           : output beat handshake
//   m_real / m_imag             : element data of current beat
//   m_index                     : source element number of current beat
//   m_last                      : high on beat 15
//   m_mag                       : |m_real| + |m_imag|, unsigned 17-bit
//   busy                        : a frame is held or streaming
//   overrun                     : one-cycle pulse when an incoming frame was dropped
module fft_4x4_out_serializer #(
  parameter int unsigned ORDER  = 0,
  parameter int unsigned MAG_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fft_done,
  input  logic [15:0] din_real_0,
  input  logic [15:0] din_real_1,
  input  logic [15:0] din_real_2,
  input  logic [15:0] din_real_3,
  input  logic [15:0] din_real_4,
  input  logic [15:0] din_real_5,
  input  logic [15:0] din_real_6,
  input  logic [15:0] din_real_7,
  input  logic [15:0] din_real_8,
  input  logic [15:0] din_real_9,
  input  logic [15:0] din_real_10,
  input  logic [15:0] din_real_11,
  input  logic [15:0] din_real_12,
  input  logic [15:0] din_real_13,
  input  logic [15:0] din_real_14,
  input  logic [15:0] din_real_15,
  input  logic [15:0] din_imag_0,
  input  logic [15:0] din_imag_1,
  input  logic [15:0] din_imag_2,
  input  logic [15:0] din_imag_3,
  input  logic [15:0] din_imag_4,
  input  logic [15:0] din_imag_5,
  input  logic [15:0] din_imag_6,
  input  logic [15:0] din_imag_7,
  input  logic [15:0] din_imag_8,
  input  logic [15:0] din_imag_9,
  input  logic [15:0] din_imag_10,
  input  logic [15:0] din_imag_11,
  input  logic [15:0] din_imag_12,
  input  logic [15:0] din_imag_13,
  input  logic [15:0] din_imag_14,
  input  logic [15:0] din_imag_15,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_real,
  output logic [15:0] m_imag,
  output logic [3:0]  m_index,
  output logic        m_last,
  output logic [16:0] m_mag,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic        armed_q;
  logic [15:0] m_real_q, m_real_d;
  logic [15:0] m_imag_q, m_imag_d;
  logic [3:0]  m_index_q, m_index_d;
  logic        m_last_q, m_last_d;
  logic [16:0] m_mag_q, m_mag_d;
  logic        overrun_q, overrun_d;

  logic [15:0] din_re [16];
  logic [15:0] din_im [16];
  logic [15:0] buf_re_q [16];
  logic [15:0] buf_im_q [16];

  logic        xfer, last_beat, capture, advance;
  logic [3:0]  next_beat, src_elem;
  logic [15:0] sel_re, sel_im;

  assign din_re[0]  = din_real_0;   assign din_im[0]  = din_imag_0;
  assign din_re[1]  = din_real_1;   assign din_im[1]  = din_imag_1;
  assign din_re[2]  = din_real_2;   assign din_im[2]  = din_imag_2;
  assign din_re[3]  = din_real_3;   assign din_im[3]  = din_imag_3;
  assign din_re[4]  = din_real_4;   assign din_im[4]  = din_imag_4;
  assign din_re[5]  = din_real_5;   assign din_im[5]  = din_imag_5;
  assign din_re[6]  = din_real_6;   assign din_im[6]  = din_imag_6;
  assign din_re[7]  = din_real_7;   assign din_im[7]  = din_imag_7;
  assign din_re[8]  = din_real_8;   assign din_im[8]  = din_imag_8;
  assign din_re[9]  = din_real_9;   assign din_im[9]  = din_imag_9;
  assign din_re[10] = din_real_10;  assign din_im[10] = din_imag_10;
  assign din_re[11] = din_real_11;  assign din_im[11] = din_imag_11;
  assign din_re[12] = din_real_12;  assign din_im[12] = din_imag_12;
  assign din_re[13] = din_real_13;  assign din_im[13] = din_imag_13;
  assign din_re[14] = din_real_14;  assign din_im[14] = din_imag_14;
  assign din_re[15] = din_real_15;  assign din_im[15] = din_imag_15;

  // Beat number to source element; column-major swaps the 2-bit row/col fields.
  function automatic logic [3:0] beat_to_elem(input logic [3:0] k);
    if (ORDER == 1) return {k[1:0], k[3:2]};
    return k;
  endfunction

  // |a| + |b| with both parts sign-extended to 17 bits so -32768 is representable.
  function automatic logic [16:0] mag_of(input logic [15:0] re, input logic [15:0] im);
    logic [16:0] ere, eim, are, aim;
    ere = {re[15], re};
    eim = {im[15], im};
    are = ere[16] ? (~ere + 17'd1) : ere;
    aim = eim[16] ? (~eim + 17'd1) : eim;
    return are + aim;
  endfunction

  always_comb begin
    xfer      = (state_q == StStream) && m_ready;
    last_beat = (beat_q == 4'd15);
    // armed_q blocks capture on the first edge after reset release.
    capture   = armed_q && fft_done && ((state_q == StIdle) || (xfer && last_beat));
    advance   = xfer && !last_beat;
    next_beat = beat_q + 4'd1;
    src_elem  = beat_to_elem(next_beat);

    // Beat 0 maps to element 0 in both orders, so a capture loads straight from din.
    sel_re = capture ? din_re[0] : buf_re_q[src_elem];
    sel_im = capture ? din_im[0] : buf_im_q[src_elem];

    state_d   = state_q;
    beat_d    = beat_q;
    m_real_d  = m_real_q;
    m_imag_d  = m_imag_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    m_mag_d   = m_mag_q;
    overrun_d = (state_q == StStream) && fft_done && !capture;

    if (capture || advance) begin
      m_real_d  = sel_re;
      m_imag_d  = sel_im;
      m_mag_d   = (MAG_EN != 0) ? mag_of(sel_re, sel_im) : 17'd0;
    end

    if (capture) begin
      state_d   = StStream;
      beat_d    = 4'd0;
      m_index_d = 4'd0;
      m_last_d  = 1'b0;
    end else if (advance) begin
      beat_d    = next_beat;
      m_index_d = src_elem;
      m_last_d  = (next_beat == 4'd15);
    end else if (xfer && last_beat) begin
      state_d   = StIdle;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      beat_q    <= 4'd0;
      armed_q   <= 1'b0;
      m_real_q  <= 16'd0;
      m_imag_q  <= 16'd0;
      m_index_q <= 4'd0;
      m_last_q  <= 1'b0;
      m_mag_q   <= 17'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      armed_q   <= 1'b1;
      m_real_q  <= m_real_d;
      m_imag_q  <= m_imag_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      m_mag_q   <= m_mag_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame buffer is pure datapath; its contents are never observed before a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 16; i++) begin
        buf_re_q[i] <= din_re[i];
        buf_im_q[i] <= din_im[i];
      end
    end
  end

  assign m_valid = (state_q == StStream);
  assign busy    = (state_q == StStream);
  assign overrun = overrun_q;
  assign m_real  = m_real_q;
  assign m_imag  = m_imag_q;
  assign m_index = m_index_q;
  assign m_last  = m_last_q;
  assign m_mag   = m_mag_q;

endmodule

// File: tb/tb_fft_4x4_out_serializer.sv
module tb_fft_4x4_out_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fft_done = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] dr [16];
  logic [15:0] di [16];

  logic        v0, l0, b0, o0, v1, l1, b1, o1;
  logic [15:0] re0, im0, re1, im1;
  logic [3:0]  ix0, ix1;
  logic [16:0] mg0, mg1;

  int checks = 0;
  int failures = 0;

  // Column-major beat order, written out by hand.
  int ord1 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  always #5 clk = ~clk;

  fft_4x4_out_serializer #(.ORDER(0), .MAG_EN(1)) dut0 (
    .clk(clk), .reset(reset), .fft_done(fft_done),
    .din_real_0(dr[0]), .din_real_1(dr[1]), .din_real_2(dr[2]), .din_real_3(dr[3]),
    .din_real_4(dr[4]), .din_real_5(dr[5]), .din_real_6(dr[6]), .din_real_7(dr[7]),
    .din_real_8(dr[8]), .din_real_9(dr[9]), .din_real_10(dr[10]), .din_real_11(dr[11]),
    .din_real_12(dr[12]), .din_real_13(dr[13]), .din_real_14(dr[14]), .din_real_15(dr[15]),
    .din_imag_0(di[0]), .din_imag_1(di[1]), .din_imag_2(di[2]), .din_imag_3(di[3]),
    .din_imag_4(di[4]), .din_imag_5(di[5]), .din_imag_6(di[6]), .din_imag_7(di[7]),
    .din_imag_8(di[8]), .din_imag_9(di[9]), .din_imag_10(di[10]), .din_imag_11(di[11]),
    .din_imag_12(di[12]), .din_imag_13(di[13]), .din_imag_14(di[14]), .din_imag_15(di[15]),
    .m_valid(v0), .m_ready(m_ready), .m_real(re0), .m_imag(im0), .m_index(ix0),
    .m_last(l0), .m_mag(mg0), .busy(b0), .overrun(o0)
  );

  fft_4x4_out_serializer #(.ORDER(1), .MAG_EN(1)) dut1 (
    .clk(clk), .reset(reset), .fft_done(fft_done),
    .din_real_0(dr[0]), .din_real_1(dr[1]), .din_real_2(dr[2]), .din_real_3(dr[3]),
    .din_real_4(dr[4]), .din_real_5(dr[5]), .din_real_6(dr[6]), .din_real_7(dr[7]),
    .din_real_8(dr[8]), .din_real_9(dr[9]), .din_real_10(dr[10]), .din_real_11(dr[11]),
    .din_real_12(dr[12]), .din_real_13(dr[13]), .din_real_14(dr[14]), .din_real_15(dr[15]),
    .din_imag_0(di[0]), .din_imag_1(di[1]), .din_imag_2(di[2]), .din_imag_3(di[3]),
    .din_imag_4(di[4]), .din_imag_5(di[5]), .din_imag_6(di[6]), .din_imag_7(di[7]),
    .din_imag_8(di[8]), .din_imag_9(di[9]), .din_imag_10(di[10]), .din_imag_11(di[11]),
    .din_imag_12(di[12]), .din_imag_13(di[13]), .din_imag_14(di[14]), .din_imag_15(di[15]),
    .m_valid(v1), .m_ready(m_ready), .m_real(re1), .m_imag(im1), .m_index(ix1),
    .m_last(l1), .m_mag(mg1), .busy(b1), .overrun(o1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp(input int base);
    for (int n = 0; n < 16; n++) begin
      dr[n] = 16'(base + n);
      di[n] = 16'(0 - n);
    end
  endtask

  task automatic apply_reset();
    fft_done = 1'b0;
    m_ready  = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", v0); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", b0); end
    checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL rst_overrun got %b want 0", o0); end
    checks++; if (l0 !== 1'b0) begin failures++; $display("FAIL rst_last got %b want 0", l0); end
    checks++; if (ix0 !== 4'd0) begin failures++; $display("FAIL rst_index got %0d want 0", ix0); end
    checks++; if (re0 !== 16'd0) begin failures++; $display("FAIL rst_real got %0h want 0", re0); end
    checks++; if (im0 !== 16'd0) begin failures++; $display("FAIL rst_imag got %0h want 0", im0); end
    checks++; if (mg0 !== 17'd0) begin failures++; $display("FAIL rst_mag got %0h want 0", mg0); end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    load_ramp(0);
    m_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 16; k++) begin
      checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL basic_valid k=%0d got %b want 1", k, v0); end
      checks++; if (re0 !== 16'(k)) begin failures++; $display("FAIL basic_real k=%0d got %0h want %0h", k, re0, 16'(k)); end
      checks++; if (im0 !== 16'(0 - k)) begin failures++; $display("FAIL basic_imag k=%0d got %0h want %0h", k, im0, 16'(0 - k)); end
      checks++; if (mg0 !== 17'(2 * k)) begin failures++; $display("FAIL basic_mag k=%0d got %0d want %0d", k, mg0, 2 * k); end
      checks++; if (ix0 !== 4'(k)) begin failures++; $display("FAIL basic_index k=%0d got %0d want %0d", k, ix0, k); end
      checks++; if (l0 !== (k == 15)) begin failures++; $display("FAIL basic_last k=%0d got %b want %b", k, l0, k == 15); end
      tick();
    end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL basic_end_valid got %b want 0", v0); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL basic_end_busy got %b want 0", b0); end
  endtask

  task automatic test_backpressure();
    int exp_k = 0;
    int stall = 0;
    apply_reset();
    load_ramp(0);
    m_ready = 1'b1;
    pulse_done();
    for (int cyc = 0; cyc < 40 && exp_k < 16; cyc++) begin
      checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got %b want 1", cyc, v0); end
      checks++; if (ix0 !== 4'(exp_k)) begin failures++; $display("FAIL bp_index cyc=%0d got %0d want %0d", cyc, ix0, exp_k); end
      checks++; if (re0 !== 16'(exp_k)) begin failures++; $display("FAIL bp_real cyc=%0d got %0h want %0h", cyc, re0, exp_k); end
      if (exp_k == 5 && stall < 3) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = 1'b1;
        exp_k++;
      end
      tick();
    end
    checks++; if (exp_k != 16) begin failures++; $display("FAIL bp_count got %0d want 16", exp_k); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL bp_end_valid got %b want 0", v0); end
  endtask

  task automatic test_overrun();
    apply_reset();
    load_ramp(0);
    m_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 8; k++) tick();
    checks++; if (ix0 !== 4'd8) begin failures++; $display("FAIL ovr_at8 got %0d want 8", ix0); end
    checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL ovr_pre got %b want 0", o0); end
    load_ramp(500);
    fft_done = 1'b1;
    m_ready  = 1'b0;
    tick();
    fft_done = 1'b0;
    checks++; if (o0 !== 1'b1) begin failures++; $display("FAIL ovr_pulse got %b want 1", o0); end
    checks++; if (re0 !== 16'd8) begin failures++; $display("FAIL ovr_hold got %0h want 8", re0); end
    m_ready = 1'b1;
    tick();
    checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL ovr_clear got %b want 0", o0); end
    for (int k = 9; k < 16; k++) begin
      checks++; if (re0 !== 16'(k)) begin failures++; $display("FAIL ovr_real k=%0d got %0h want %0h", k, re0, k); end
      tick();
    end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL ovr_end_valid got %b want 0", v0); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    load_ramp(0);
    m_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 16; k++) begin
      checks++; if (re0 !== 16'(k)) begin failures++; $display("FAIL b2b_f1 k=%0d got %0h want %0h", k, re0, k); end
      if (k == 15) begin
        load_ramp(100);
        fft_done = 1'b1;
      end
      tick();
    end
    fft_done = 1'b0;
    checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL b2b_valid got %b want 1", v0); end
    checks++; if (ix0 !== 4'd0) begin failures++; $display("FAIL b2b_index got %0d want 0", ix0); end
    checks++; if (l0 !== 1'b0) begin failures++; $display("FAIL b2b_last got %b want 0", l0); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (re0 !== 16'(100 + k)) begin failures++; $display("FAIL b2b_f2 k=%0d got %0d want %0d", k, re0, 100 + k); end
      checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL b2b_f2_valid k=%0d got %b want 1", k, v0); end
      tick();
    end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got %b want 0", v0); end
  endtask

  task automatic test_order_extremes();
    int e;
    apply_reset();
    load_ramp(0);
    dr[6] = 16'h8000;  di[6] = 16'h8000;  // |re|+|im| = 65536
    dr[7] = 16'h7fff;  di[7] = 16'h8000;  // 32767 + 32768 = 65535
    m_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 16; k++) begin
      e = ord1[k];
      checks++; if (ix1 !== 4'(e)) begin failures++; $display("FAIL ord1_index k=%0d got %0d want %0d", k, ix1, e); end
      checks++; if (re1 !== dr[e]) begin failures++; $display("FAIL ord1_real k=%0d got %0h want %0h", k, re1, dr[e]); end
      checks++; if (l1 !== (k == 15)) begin failures++; $display("FAIL ord1_last k=%0d got %b want %b", k, l1, k == 15); end
      if (k == 9) begin
        checks++; if (mg1 !== 17'd65536) begin failures++; $display("FAIL ord1_mag_min got %0d want 65536", mg1); end
      end
      if (k == 6) begin
        checks++; if (mg0 !== 17'd65536) begin failures++; $display("FAIL ord0_mag_min got %0d want 65536", mg0); end
      end
      if (k == 7) begin
        checks++; if (mg0 !== 17'd65535) begin failures++; $display("FAIL ord0_mag_mix got %0d want 65535", mg0); end
      end
      tick();
    end
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL ord1_end_valid got %b want 0", v1); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    load_ramp(0);
    m_ready = 1'b1;
    pulse_done();
    for (int k = 0; k < 6; k++) tick();
    checks++; if (ix0 !== 4'd6) begin failures++; $display("FAIL ar_at6 got %0d want 6", ix0); end
    #2;
    reset    = 1'b0;
    fft_done = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL ar_valid got %b want 0", v0); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL ar_busy got %b want 0", b0); end
    checks++; if (re0 !== 16'd0) begin failures++; $display("FAIL ar_real got %0h want 0", re0); end
    #2;
    reset = 1'b1;
    tick();
    fft_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL ar_quiet c=%0d got %b want 0", c, v0); end
      tick();
    end
    load_ramp(40);
    pulse_done();
    checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL ar_new_valid got %b want 1", v0); end
    checks++; if (re0 !== 16'd40) begin failures++; $display("FAIL ar_new_real got %0d want 40", re0); end
  endtask

  initial begin
    load_ramp(0);
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_order_extremes();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
